// File: rtl/uart_message_tx.sv
// uart_message_tx: looks up one byte of a fixed 16-character message ROM on
// each accepted enable strobe and sends it as a UART frame on tx (LSB first).
// Bit timing comes from a phase accumulator, so any clock/baud ratio works.
// Optional build macro: UART_MSG_PARITY_EN adds an even-parity bit (8E1);
// without it the frame is 8N1.
module uart_message_tx #(
  parameter int CLK_FREQ = 48000000,
  parameter int BAUD     = 115200,
  parameter int ACC_W    = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en_in,
  input  logic [3:0] index,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic       overrun
);

  localparam logic [63:0]      INC64 = (64'(BAUD) << ACC_W) / 64'(CLK_FREQ);
  localparam logic [ACC_W-1:0] INC   = INC64[ACC_W-1:0];

`ifdef UART_MSG_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_nxt;
  logic [7:0]       shreg;
  logic [2:0]       bitcnt;
  logic [7:0]       rom_byte;
  logic             tick;
  logic             look;
`ifdef UART_MSG_PARITY_EN
  logic             par;
`endif

  function automatic logic [7:0] rom(input logic [3:0] i);
    case (i)
      4'd0:    rom = 8'h48; // H
      4'd1:    rom = 8'h45; // E
      4'd2:    rom = 8'h4C; // L
      4'd3:    rom = 8'h4C; // L
      4'd4:    rom = 8'h4F; // O
      4'd5:    rom = 8'h20; // space
      4'd6:    rom = 8'h55; // U
      4'd7:    rom = 8'h41; // A
      4'd8:    rom = 8'h52; // R
      4'd9:    rom = 8'h54; // T
      4'd10:   rom = 8'h20; // space
      4'd11:   rom = 8'h30; // 0
      4'd12:   rom = 8'h31; // 1
      4'd13:   rom = 8'h32; // 2
      4'd14:   rom = 8'h33; // 3
      default: rom = 8'h0A; // line feed
    endcase
  endfunction

  assign rom_byte = rom(index);

  // acc + INC carries out exactly when acc > ~INC, so the carry is a compare.
  // tick: the bit boundary falls on the coming edge.
  // look: the boundary falls on the edge after that; lets done be registered
  // yet still sit in the last stop-bit cycle.
  assign acc_nxt = acc + INC;
  assign tick    = (acc > ~INC);
  assign look    = (acc_nxt > ~INC);

  // Frame FSM, baud accumulator and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      acc     <= '0;
      shreg   <= '0;
      bitcnt  <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      overrun <= 1'b0;
`ifdef UART_MSG_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      done    <= 1'b0;
      overrun <= en_in && (state != IDLE);
      acc     <= (state == IDLE) ? '0 : acc_nxt;
      case (state)
        IDLE: begin
          if (en_in) begin
            shreg  <= rom_byte;
            bitcnt <= '0;
`ifdef UART_MSG_PARITY_EN
            par    <= ^rom_byte;
`endif
            state  <= START;
            tx     <= 1'b0;
            busy   <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            state <= DATA;
            tx    <= shreg[0];
          end
        end
        DATA: begin
          if (tick) begin
            shreg  <= shreg >> 1;
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) begin
`ifdef UART_MSG_PARITY_EN
              state <= PARITY;
              tx    <= par;
`else
              state <= STOP;
              tx    <= 1'b1;
              done  <= look;
`endif
            end else begin
              tx <= shreg[1];
            end
          end
        end
`ifdef UART_MSG_PARITY_EN
        PARITY: begin
          if (tick) begin
            state <= STOP;
            tx    <= 1'b1;
            done  <= look;
          end
        end
`endif
        STOP: begin
          if (tick) begin
            state <= IDLE;
            busy  <= 1'b0;
            acc   <= '0;
          end else begin
            done <= look;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_message_tx.sv
// Self-checking bench for uart_message_tx. Frame timing is predicted from the
// bit-boundary arithmetic ceil(k * 2^32 / INC) and compared cycle by cycle.
// Honours UART_MSG_PARITY_EN the same way the design does.
module tb_uart_message_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       en_in;
  logic [3:0] index;
  logic       tx, busy, done, overrun;

  always #5 clk = ~clk;

  uart_message_tx #(.CLK_FREQ(48000000), .BAUD(115200), .ACC_W(32)) dut (
    .clk(clk), .reset(reset), .en_in(en_in), .index(index),
    .tx(tx), .busy(busy), .done(done), .overrun(overrun)
  );

`ifdef UART_MSG_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam longint unsigned TWO32 = 64'd1 << 32;
  localparam longint unsigned INC_M = (64'd115200 * TWO32) / 64'd48000000;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] idx;
    logic [7:0] ch;
    int         q;     // offset of an extra en_in pulse, -1 none
    int         r;     // offset of a reset pulse, -1 none
    int         tail;  // idle cycles after the frame
    logic [3:0] qidx;  // index presented with the extra pulse
  } vec_t;

  vec_t vecs[$];
  logic [7:0] msg [16] = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h20, 8'h55, 8'h41,
                           8'h52, 8'h54, 8'h20, 8'h30, 8'h31, 8'h32, 8'h33, 8'h0A};

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Cycle offset (from the first start-bit cycle) where bit k begins.
  function automatic int bnd(input int k);
    longint unsigned kk;
    kk = longint'(k);
    return int'((kk * TWO32 + INC_M - 1) / INC_M);
  endfunction

  function automatic int mid(input int j);
    longint unsigned jj;
    jj = longint'(2 * j + 1);
    return int'((jj * TWO32) / (2 * INC_M));
  endfunction

  // Expected {tx, busy, done, overrun} at cycle offset off of a frame.
  function automatic logic [3:0] model(input logic [7:0] b, input int off,
                                       input int r, input int q);
    int   flen, j;
    logic etx, eb, ed, eo;
    flen = bnd(NB);
    eo = (q >= 0) && (off == q + 1);
    if ((r >= 0 && off > r) || off >= flen) begin
      etx = 1'b1; eb = 1'b0; ed = 1'b0;
      if (r >= 0 && off > r) eo = 1'b0;
    end else begin
      j = 0;
      for (int k = 1; k <= NB; k++) if (bnd(k) <= off) j++;
      if (j == 0)                 etx = 1'b0;
      else if (j <= 8)            etx = b[j-1];
      else if (j == 9 && NB == 11) etx = ^b;
      else                        etx = 1'b1;
      eb = 1'b1;
      ed = (off == flen - 1);
    end
    return {etx, eb, ed, eo};
  endfunction

  task automatic run_frame(input vec_t v);
    int         flen, last;
    int         bad_off [4];
    logic       bad_act [4];
    logic       bad_exp [4];
    logic [3:0] e, a;
    logic [10:0] dec, ef;
    string      nm [4];
    nm[0] = "tx"; nm[1] = "busy"; nm[2] = "done"; nm[3] = "overrun";
    for (int s = 0; s < 4; s++) begin
      bad_off[s] = -1; bad_act[s] = 1'b0; bad_exp[s] = 1'b0;
    end
    dec  = '0;
    flen = bnd(NB);
    last = (v.r >= 0) ? v.r + 1 + v.tail : flen + v.tail;
    en_in = 1'b1;
    index = v.idx;
    @(posedge clk);
    @(negedge clk);
    for (int off = 0; off <= last; off++) begin
      e = model(v.ch, off, v.r, v.q);
      a = {tx, busy, done, overrun};
      for (int s = 0; s < 4; s++) begin
        if (bad_off[s] < 0 && a[3-s] !== e[3-s]) begin
          bad_off[s] = off; bad_act[s] = a[3-s]; bad_exp[s] = e[3-s];
        end
      end
      for (int j = 0; j < NB; j++) if (off == mid(j)) dec[j] = tx;
      en_in = (off == v.q);
      index = (off == v.q) ? v.qidx : 4'($urandom);
      reset = (off == v.r);
      if (off < last) @(negedge clk);
    end
    en_in = 1'b0;
    reset = 1'b0;
    for (int s = 0; s < 4; s++) begin
      checks++;
      if (bad_off[s] >= 0) begin
        errors++;
        $display("FAIL %s_trace idx=%0d cycle=%0d: got %b expected %b",
                 nm[s], v.idx, bad_off[s], bad_act[s], bad_exp[s]);
      end
    end
    if (v.r < 0) begin
      ef = '0;
      ef[8:1] = v.ch;
      if (NB == 11) ef[9] = ^v.ch;
      ef[NB-1] = 1'b1;
      check($sformatf("decode idx=%0d", v.idx), int'(dec), int'(ef));
    end
  endtask

  initial begin
    vec_t v;
    reset = 1'b1;
    en_in = 1'b0;
    index = '0;

    // Reset state, then reset winning over a simultaneous request.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_tx", int'(tx), 1);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_overrun", int'(overrun), 0);
    en_in = 1'b1;
    @(negedge clk);
    check("reset_vs_en_busy", int'(busy), 0);
    check("reset_vs_en_tx", int'(tx), 1);
    reset = 1'b0;
    en_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_outputs", int'({tx, busy, done, overrun}), 8);
    end

    // Full message, random gaps and random dropped requests.
    for (int i = 0; i < 16; i++) begin
      v.idx  = 4'(i);
      v.ch   = msg[i];
      v.r    = -1;
      v.tail = int'($urandom_range(0, 3));
      v.qidx = 4'($urandom);
      v.q    = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, bnd(NB) - 1)) : -1;
      if (i == 3) begin v.q = 1000; v.qidx = 4'd5; end
      if (i == 7) v.q = bnd(NB) - 1;
      if (i == 8) v.tail = 0;
      vecs.push_back(v);
    end
    foreach (vecs[i]) run_frame(vecs[i]);

    // Reset during data bit 3, then a clean line-feed frame.
    v.idx = 4'd6; v.ch = 8'h55; v.q = -1; v.r = bnd(4) + 10; v.tail = 3; v.qidx = '0;
    run_frame(v);
    v.idx = 4'd15; v.ch = 8'h0A; v.q = -1; v.r = -1; v.tail = 20;
    run_frame(v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
